// File: rtl/dbram_if.sv
// Purpose: bundles the core load/store BRAM port and the host (loader/debug)
// req/gnt port of the data BRAM responder.
// Ports (master -> responder):
//   addr, en, be, data_in                    core word address, strobe, byte enables, write data
//   host_req, host_addr, host_be, host_wdata host request and its access fields
// Ports (responder -> master):
//   data_out                                 core read data, registered
//   host_gnt, host_rvalid, host_rdata        host grant pulse, read-valid pulse, read data
//   host_starve                              host has waited the starvation limit
interface dbram_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [ADDR_W-1:0] addr;
    logic              en;
    logic [3:0]        be;
    logic [31:0]       data_in;
    logic [31:0]       data_out;

    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic [3:0]        host_be;
    logic [31:0]       host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [31:0]       host_rdata;
    logic              host_starve;

    modport master (
        output addr, en, be, data_in,
        output host_req, host_addr, host_be, host_wdata,
        input  data_out, host_gnt, host_rvalid, host_rdata, host_starve
    );

    modport slave (
        input  addr, en, be, data_in,
        input  host_req, host_addr, host_be, host_wdata,
        output data_out, host_gnt, host_rvalid, host_rdata, host_starve
    );
endinterface

// File: rtl/dbram_responder.sv
// Purpose: DEPTH x 32 byte-writable single-ported data RAM. The core port has
// absolute priority and one-cycle registered read latency (read-first); a host
// port shares the array through a combinational req/gnt handshake and gets a
// starvation flag after STARVE_LIMIT consecutive waiting cycles.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-low reset (array contents are not reset)
//   bus   dbram_if.slave: core access port plus host req/gnt port
module dbram_responder #(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned STARVE_LIMIT = 64,
    parameter string       INIT_FILE    = ""
) (
    input  logic     clk,
    input  logic     rst,
    dbram_if.slave   bus
);

    localparam int unsigned CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [31:0] mem [DEPTH];

    logic              gnt_c;
    logic              host_rd_c;
    logic              acc_c;
    logic [ADDR_W-1:0] acc_addr_c;
    logic [3:0]        acc_be_c;
    logic [31:0]       acc_wdata_c;
    logic [31:0]       rd_word_c;

    logic [31:0]       data_out_q;
    logic              rvalid_q;
    logic [31:0]       rdata_q;
    logic [CNT_W-1:0]  wait_cnt_q;

    // Host only gets the array on cycles the core leaves idle; reset drops any grant
    assign gnt_c     = bus.host_req & ~bus.en & rst;
    assign host_rd_c = gnt_c & (bus.host_be == 4'h0);

    // Single access-port mux: core wins whenever it strobes
    always_comb begin
        acc_c       = (bus.en & rst) | gnt_c;
        acc_addr_c  = bus.host_addr;
        acc_be_c    = bus.host_be;
        acc_wdata_c = bus.host_wdata;
        if (bus.en) begin
            acc_addr_c  = bus.addr;
            acc_be_c    = bus.be;
            acc_wdata_c = bus.data_in;
        end
    end

    // Pre-write word; sampled on the same edge as the write gives read-first
    assign rd_word_c = mem[acc_addr_c];

    // Byte-lane writes into the array
    always_ff @(posedge clk) begin
        if (acc_c) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be_c[i]) begin
                    mem[acc_addr_c][8*i +: 8] <= acc_wdata_c[8*i +: 8];
                end
            end
        end
    end

    // Registered read data, host read-valid and starvation counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_q <= 32'h0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'h0;
            wait_cnt_q <= '0;
        end else begin
            if (bus.en) begin
                data_out_q <= rd_word_c;
            end
            rvalid_q <= host_rd_c;
            if (host_rd_c) begin
                rdata_q <= rd_word_c;
            end
            if (!bus.host_req || gnt_c) begin
                wait_cnt_q <= '0;
            end else if (wait_cnt_q != CNT_MAX) begin
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.host_gnt    = gnt_c;
    assign bus.host_rvalid = rvalid_q;
    assign bus.host_rdata  = rdata_q;
    assign bus.host_starve = (wait_cnt_q == CNT_MAX);

endmodule

// File: tb/tb_dbram_responder.sv
// Purpose: directed bench for dbram_responder with queue-based scoreboards for
// core read data and host read data, plus inline checks of grant, starvation
// and reset behaviour.
module tb_dbram_responder;

    localparam int unsigned ADDR_W = 10;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dbram_if #(.ADDR_W(ADDR_W)) ifc ();

    dbram_responder #(
        .DEPTH        (1024),
        .ADDR_W       (ADDR_W),
        .STARVE_LIMIT (64),
        .INIT_FILE    ("")
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (ifc)
    );

    typedef struct {
        logic        skip;
        logic [31:0] v;
    } exp_t;

    exp_t core_q[$];
    exp_t host_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check32(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Marks edges where the core performed an access, so data_out is due after it
    logic core_fire;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) core_fire <= 1'b0;
        else        core_fire <= ifc.en;
    end

    // Monitor: pops expectations whenever the DUT presents read data
    always @(negedge clk) begin
        exp_t e;
        if (core_fire) begin
            if (core_q.size() == 0) begin
                check32("core_rd_unexpected", ifc.data_out, 32'hxxxxxxxx);
            end else begin
                e = core_q.pop_front();
                if (!e.skip) check32("core_rd", ifc.data_out, e.v);
            end
        end
        if (ifc.host_rvalid) begin
            if (host_q.size() == 0) begin
                check1("host_rvalid_unexpected", ifc.host_rvalid, 1'b0);
            end else begin
                e = host_q.pop_front();
                check32("host_rd", ifc.host_rdata, e.v);
            end
        end
    end

    // Host fields must stay stable while a request is pending
    logic              pend_q = 1'b0;
    logic [ADDR_W-1:0] pa_q;
    logic [3:0]        pb_q;
    logic [31:0]       pw_q;
    always @(posedge clk) begin
        if (pend_q && ifc.host_req &&
            ({ifc.host_addr, ifc.host_be, ifc.host_wdata} != {pa_q, pb_q, pw_q})) begin
            n_checks++;
            $display("FAIL host_stable: fields changed while pending addr %h be %h", ifc.host_addr, ifc.host_be);
        end
        pend_q <= ifc.host_req & ~ifc.host_gnt;
        pa_q   <= ifc.host_addr;
        pb_q   <= ifc.host_be;
        pw_q   <= ifc.host_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_op(input logic [ADDR_W-1:0] a, input logic [3:0] b,
                           input logic [31:0] d, input logic skip, input logic [31:0] exp);
        ifc.en      = 1'b1;
        ifc.addr    = a;
        ifc.be      = b;
        ifc.data_in = d;
        core_q.push_back('{skip, exp});
        tick();
        ifc.en = 1'b0;
    endtask

    task automatic host_op(input logic [ADDR_W-1:0] a, input logic [3:0] b,
                           input logic [31:0] d, input logic [31:0] exp);
        ifc.host_req   = 1'b1;
        ifc.host_addr  = a;
        ifc.host_be    = b;
        ifc.host_wdata = d;
        #1;
        check1("host_gnt_idle", ifc.host_gnt, 1'b1);
        if (b == 4'h0) host_q.push_back('{1'b0, exp});
        tick();
        ifc.host_req = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        ifc.en         = 1'b0;
        ifc.addr       = '0;
        ifc.be         = 4'h0;
        ifc.data_in    = 32'h0;
        ifc.host_req   = 1'b0;
        ifc.host_addr  = '0;
        ifc.host_be    = 4'h0;
        ifc.host_wdata = 32'h0;

        tick();
        tick();
        check32("rst_data_out",    ifc.data_out,    32'h0);
        check1 ("rst_host_gnt",    ifc.host_gnt,    1'b0);
        check1 ("rst_host_rvalid", ifc.host_rvalid, 1'b0);
        check32("rst_host_rdata",  ifc.host_rdata,  32'h0);
        check1 ("rst_host_starve", ifc.host_starve, 1'b0);
        rst_n = 1'b1;
        tick();

        // Core full-word writes and read-back, read-first on writes
        core_op(10'd5, 4'hF, 32'h11111111, 1'b1, 32'h0);
        core_op(10'd5, 4'hF, 32'hDEADBEEF, 1'b0, 32'h11111111);
        core_op(10'd5, 4'h0, 32'h0,        1'b0, 32'hDEADBEEF);
        tick();
        check32("data_out_hold", ifc.data_out, 32'hDEADBEEF);

        // Single byte-lane write
        core_op(10'd5, 4'b0100, 32'h00AA0000, 1'b0, 32'hDEADBEEF);
        core_op(10'd5, 4'h0,    32'h0,        1'b0, 32'hDEAABEEF);

        // Host read and host write while the core is idle
        host_op(10'd5, 4'h0, 32'h0, 32'hDEAABEEF);
        tick();
        host_op(10'd9, 4'hF, 32'h12345678, 32'h0);
        tick();
        check32("host_rdata_hold", ifc.host_rdata, 32'hDEAABEEF);
        core_op(10'd9, 4'h0, 32'h0, 1'b0, 32'h12345678);

        // Starvation: core busy for 70 cycles with a host read pending
        ifc.host_req  = 1'b1;
        ifc.host_addr = 10'd5;
        ifc.host_be   = 4'h0;
        for (int k = 1; k <= 70; k++) begin
            ifc.en   = 1'b1;
            ifc.addr = 10'd9;
            ifc.be   = 4'h0;
            core_q.push_back('{1'b0, 32'h12345678});
            tick();
            if (k == 63) check1("starve_63", ifc.host_starve, 1'b0);
            if (k == 64) check1("starve_64", ifc.host_starve, 1'b1);
            if (k == 70) begin
                check1("starve_70",     ifc.host_starve, 1'b1);
                check1("gnt_while_busy", ifc.host_gnt,   1'b0);
            end
        end
        ifc.en = 1'b0;
        #1;
        check1("gnt_after_busy",   ifc.host_gnt,    1'b1);
        check1("starve_at_grant",  ifc.host_starve, 1'b1);
        host_q.push_back('{1'b0, 32'hDEAABEEF});
        tick();
        ifc.host_req = 1'b0;
        check1("starve_after_gnt", ifc.host_starve, 1'b0);
        tick();

        // Same-cycle core and host writes to address 7
        ifc.en        = 1'b1;
        ifc.addr      = 10'd7;
        ifc.be        = 4'hF;
        ifc.data_in   = 32'hAAAA0007;
        core_q.push_back('{1'b1, 32'h0});
        ifc.host_req   = 1'b1;
        ifc.host_addr  = 10'd7;
        ifc.host_be    = 4'hF;
        ifc.host_wdata = 32'hBBBB0007;
        #1;
        check1("gnt_collision", ifc.host_gnt, 1'b0);
        tick();
        ifc.en = 1'b0;
        #1;
        check1("gnt_next_idle", ifc.host_gnt, 1'b1);
        tick();
        ifc.host_req = 1'b0;
        core_op(10'd7, 4'h0, 32'h0, 1'b0, 32'hBBBB0007);

        // Reset while a host read is granted but not yet completed
        ifc.host_req  = 1'b1;
        ifc.host_addr = 10'd7;
        ifc.host_be   = 4'h0;
        #1;
        check1("gnt_pre_reset", ifc.host_gnt, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check1 ("mid_rst_gnt",      ifc.host_gnt,    1'b0);
        check1 ("mid_rst_rvalid",   ifc.host_rvalid, 1'b0);
        check32("mid_rst_rdata",    ifc.host_rdata,  32'h0);
        check32("mid_rst_data_out", ifc.data_out,    32'h0);
        check1 ("mid_rst_starve",   ifc.host_starve, 1'b0);
        ifc.host_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Array contents survive reset
        core_op(10'd7, 4'h0, 32'h0, 1'b0, 32'hBBBB0007);
        core_op(10'd5, 4'h0, 32'h0, 1'b0, 32'hDEAABEEF);
        host_op(10'd9, 4'h0, 32'h0, 32'h12345678);
        tick();
        tick();
        tick();

        check32("core_q_drained", 32'(core_q.size()), 32'h0);
        check32("host_q_drained", 32'(host_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
